// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the TSC multi-cycle controller: FSM states,
// instruction classes, opcode/func field values, ALU function codes and
// the encodings of the datapath mux selects.
package tsc_pkg;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_RALU, CL_ADI, CL_ORI, CL_LHI, CL_LWD, CL_SWD, CL_BRANCH,
    CL_JMP, CL_JAL, CL_JPR, CL_JRL, CL_WWD, CL_HLT, CL_ILLEGAL
  } inst_class_t;

  // opcode field IR[15:12]
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // func field IR[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // alu_ctrl codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BGZ = 4'd11;
  localparam logic [3:0] ALU_BLZ = 4'd12;

  // pc_src
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  // alu_src_b
  localparam logic [1:0] ALU_B_RT   = 2'd0;
  localparam logic [1:0] ALU_B_SIMM = 2'd1;
  localparam logic [1:0] ALU_B_ZIMM = 2'd2;
  localparam logic [1:0] ALU_B_LHI  = 2'd3;

  // reg_dst
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_R2 = 2'd2;

  // wb_sel
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port handshake.
//   read_m / write_m : request from the controller (never both high)
//   mem_ready        : completion of the current request, from memory
interface multicycle_controller_if;
  logic read_m;
  logic write_m;
  logic mem_ready;

  modport master (output read_m, output write_m, input mem_ready);
  modport slave  (input read_m, input write_m, output mem_ready);
endinterface

// File: rtl/multicycle_controller_inst_decode.sv
// Combinational instruction decode.
//   opcode, func : IR fields
//   inst_class   : instruction class consumed by the control FSM
//   alu_fn       : ALU function code used during EX
module inst_decode
  import tsc_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  func,
  output inst_class_t inst_class,
  output logic [3:0]  alu_fn
);

  always_comb begin
    inst_class = CL_ILLEGAL;
    alu_fn     = ALU_ADD;
    case (opcode)
      OP_BNE:   begin inst_class = CL_BRANCH; alu_fn = ALU_BNE; end
      OP_BEQ:   begin inst_class = CL_BRANCH; alu_fn = ALU_BEQ; end
      OP_BGZ:   begin inst_class = CL_BRANCH; alu_fn = ALU_BGZ; end
      OP_BLZ:   begin inst_class = CL_BRANCH; alu_fn = ALU_BLZ; end
      OP_ADI:   begin inst_class = CL_ADI;    alu_fn = ALU_ADD; end
      OP_ORI:   begin inst_class = CL_ORI;    alu_fn = ALU_ORR; end
      OP_LHI:   begin inst_class = CL_LHI;    alu_fn = ALU_LHI; end
      OP_LWD:   begin inst_class = CL_LWD;    alu_fn = ALU_ADD; end
      OP_SWD:   begin inst_class = CL_SWD;    alu_fn = ALU_ADD; end
      OP_JMP:   inst_class = CL_JMP;
      OP_JAL:   inst_class = CL_JAL;
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin inst_class = CL_RALU; alu_fn = ALU_ADD; end
          FN_SUB: begin inst_class = CL_RALU; alu_fn = ALU_SUB; end
          FN_AND: begin inst_class = CL_RALU; alu_fn = ALU_AND; end
          FN_ORR: begin inst_class = CL_RALU; alu_fn = ALU_ORR; end
          FN_NOT: begin inst_class = CL_RALU; alu_fn = ALU_NOT; end
          FN_TCP: begin inst_class = CL_RALU; alu_fn = ALU_TCP; end
          FN_SHL: begin inst_class = CL_RALU; alu_fn = ALU_SHL; end
          FN_SHR: begin inst_class = CL_RALU; alu_fn = ALU_SHR; end
          FN_JPR: inst_class = CL_JPR;
          FN_JRL: inst_class = CL_JRL;
          FN_WWD: inst_class = CL_WWD;
          FN_HLT: inst_class = CL_HLT;
          default: inst_class = CL_ILLEGAL;
        endcase
      end
      default: inst_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit TSC datapath.
//   clk, reset      : clock, synchronous active-high reset
//   opcode, func    : IR fields (valid from ID onward)
//   branch_taken    : datapath branch condition (valid in EX)
//   mem_bus         : shared memory request/ready handshake (master side)
//   ir_write .. wb_sel : datapath strobes and mux selects
//   output_port_flag, illegal : one-cycle WWD / undefined-instruction strobes
//   is_halted       : HLT has retired
//   num_inst        : retired-instruction counter (wraps)
module multicycle_controller
  import tsc_pkg::*;
#(
  parameter int NUM_INST_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              opcode,
  input  logic [5:0]              func,
  input  logic                    branch_taken,
  multicycle_controller_if.master mem_bus,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [3:0]              alu_ctrl,
  output logic                    reg_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              wb_sel,
  output logic                    output_port_flag,
  output logic                    illegal,
  output logic                    is_halted,
  output logic [NUM_INST_W-1:0]   num_inst
);

  state_t                state, next_state;
  inst_class_t           inst_class;
  logic [3:0]            alu_fn;
  logic                  read_req, write_req, retire;
  logic [NUM_INST_W-1:0] inst_cnt;

  inst_decode u_decode (
    .opcode     (opcode),
    .func       (func),
    .inst_class (inst_class),
    .alu_fn     (alu_fn)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset)       inst_cnt <= '0;
    else if (retire) inst_cnt <= inst_cnt + NUM_INST_W'(1);
  end

  always_comb begin
    next_state       = state;
    read_req         = 1'b0;
    write_req        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = PC_SRC_SEQ;
    alu_src_a        = 1'b0;
    alu_src_b        = ALU_B_RT;
    alu_ctrl         = ALU_ADD;
    reg_write        = 1'b0;
    reg_dst          = REG_DST_RT;
    wb_sel           = WB_ALU;
    output_port_flag = 1'b0;
    illegal          = 1'b0;
    is_halted        = 1'b0;
    retire           = 1'b0;

    unique case (state)
      S_IF: begin
        read_req = 1'b1;
        if (mem_bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        case (inst_class)
          CL_JMP: begin
            pc_write = 1'b1; pc_src = PC_SRC_JUMP;
            next_state = S_IF; retire = 1'b1;
          end
          CL_JPR: begin
            pc_write = 1'b1; pc_src = PC_SRC_REG;
            next_state = S_IF; retire = 1'b1;
          end
          CL_WWD: begin
            output_port_flag = 1'b1;
            next_state = S_IF; retire = 1'b1;
          end
          CL_HLT: begin
            next_state = S_HALT; retire = 1'b1;
          end
          CL_ILLEGAL: begin
            illegal = 1'b1;
            next_state = S_IF; retire = 1'b1;
          end
          CL_JAL, CL_JRL: next_state = S_WB;
          default:        next_state = S_EX;
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = alu_fn;
        case (inst_class)
          CL_ADI:         alu_src_b = ALU_B_SIMM;
          CL_ORI:         alu_src_b = ALU_B_ZIMM;
          CL_LHI:         alu_src_b = ALU_B_LHI;
          CL_LWD, CL_SWD: alu_src_b = ALU_B_SIMM;
          default:        alu_src_b = ALU_B_RT;
        endcase
        case (inst_class)
          CL_BRANCH: begin
            pc_write = branch_taken; pc_src = PC_SRC_BRANCH;
            next_state = S_IF; retire = 1'b1;
          end
          CL_LWD, CL_SWD: next_state = S_MEM;
          default:        next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (inst_class == CL_LWD) read_req = 1'b1;
        else                      write_req = 1'b1;
        if (mem_bus.mem_ready) begin
          if (inst_class == CL_LWD) begin
            next_state = S_WB;
          end else begin
            next_state = S_IF; retire = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        next_state = S_IF;
        retire     = 1'b1;
        case (inst_class)
          CL_RALU: reg_dst = REG_DST_RD;
          CL_LWD:  wb_sel  = WB_MEM;
          CL_JAL: begin
            reg_dst = REG_DST_R2; wb_sel = WB_PC;
            pc_write = 1'b1; pc_src = PC_SRC_JUMP;
          end
          CL_JRL: begin
            reg_dst = REG_DST_R2; wb_sel = WB_PC;
            pc_write = 1'b1; pc_src = PC_SRC_REG;
          end
          default: ;
        endcase
      end
      S_HALT: is_halted = 1'b1;
      default: next_state = S_IF;
    endcase

    // Reset is synchronous, but outputs must already be quiet in the reset
    // cycle itself, so the whole decoded output set is masked here.
    if (reset) begin
      read_req = 1'b0; write_req = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
      pc_src = '0; alu_src_a = 1'b0; alu_src_b = '0; alu_ctrl = '0;
      reg_write = 1'b0; reg_dst = '0; wb_sel = '0; output_port_flag = 1'b0;
      illegal = 1'b0; is_halted = 1'b0; retire = 1'b0;
    end
  end

  assign mem_bus.read_m  = read_req;
  assign mem_bus.write_m = write_req;
  assign num_inst        = reset ? '0 : inst_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          branch_taken = 1'b0;
  logic          ir_write, pc_write, alu_src_a, reg_write;
  logic          output_port_flag, illegal, is_halted;
  logic [1:0]    pc_src, alu_src_b, reg_dst, wb_sel;
  logic [3:0]    alu_ctrl;
  logic [NW-1:0] num_inst;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int cycles; int rd_if; int rd_mem; int wr; int pcw_late; int regw;
    int irw; int opf; int ill; int both; int regw_cycle;
    logic [1:0] pcsrc; logic [1:0] regdst; logic [1:0] wbsel;
  } obs_t;

  obs_t obs;
  int   exp_q[$];

  multicycle_controller_if bus ();

  multicycle_controller #(.NUM_INST_W(NW)) dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .func             (func),
    .branch_taken     (branch_taken),
    .mem_bus          (bus),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .alu_ctrl         (alu_ctrl),
    .reg_write        (reg_write),
    .reg_dst          (reg_dst),
    .wb_sel           (wb_sel),
    .output_port_flag (output_port_flag),
    .illegal          (illegal),
    .is_halted        (is_halted),
    .num_inst         (num_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Cycle counts with zero-wait memory, plus one per wait cycle.
  function automatic int exp_latency(input logic [3:0] op, input logic [5:0] fn,
                                     input int fw, input int mw);
    int base;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: base = 3;
      4'd4, 4'd5, 4'd6:       base = 4;
      4'd7:                   base = 5 + mw;
      4'd8:                   base = 4 + mw;
      4'd9:                   base = 2;
      4'd10:                  base = 3;
      4'd15: begin
        if (fn <= 6'd7)        base = 4;
        else if (fn == 6'd26)  base = 3;
        else                   base = 2;
      end
      default:                base = 2;
    endcase
    return base + fw;
  endfunction

  function automatic int exp_regw(input logic [3:0] op, input logic [5:0] fn);
    if (op >= 4'd4 && op <= 4'd7) return 1;
    if (op == 4'd10) return 1;
    if (op == 4'd15 && (fn <= 6'd7 || fn == 6'd26)) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Plays memory and IR for one instruction; records what the DUT did.
  task automatic run_inst(input logic [3:0] op, input logic [5:0] fn,
                          input int fetch_wait, input int mem_wait, input logic br);
    logic [NW-1:0] start;
    bit fetched, irw_now;
    int fcnt, mcnt;
    start = num_inst;
    fetched = 0; fcnt = 0; mcnt = 0;
    obs = '{default: 0};
    obs.cycles = -1;
    opcode = 4'd0; func = 6'd0; branch_taken = br;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      #1;
      if (!fetched)                          bus.mem_ready = (fcnt >= fetch_wait);
      else if (bus.read_m || bus.write_m)    bus.mem_ready = (mcnt >= mem_wait);
      else                                   bus.mem_ready = 1'b1;
      #1;
      irw_now = ir_write;
      if (bus.read_m && bus.write_m) obs.both++;
      if (!fetched) begin
        if (bus.read_m) begin obs.rd_if++; fcnt++; end
      end else begin
        if (bus.read_m) obs.rd_mem++;
        if (bus.write_m) obs.wr++;
        if (bus.read_m || bus.write_m) mcnt++;
        if (pc_write) begin obs.pcw_late++; obs.pcsrc = pc_src; end
      end
      if (ir_write) obs.irw++;
      if (reg_write) begin
        obs.regw++; obs.regw_cycle = k; obs.regdst = reg_dst; obs.wbsel = wb_sel;
      end
      if (output_port_flag) obs.opf++;
      if (illegal) obs.ill++;
      @(posedge clk);
      #1;
      if (irw_now) begin fetched = 1; opcode = op; func = fn; end
      if (num_inst != start) begin obs.cycles = k; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; bus.mem_ready = 1'b1; opcode = 4'd15; func = 6'd0;
    @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ((bus.read_m | bus.write_m | ir_write | pc_write | reg_write |
         output_port_flag | illegal | is_halted) !== 1'b0)
      $display("FAIL reset_strobes: got nonzero strobe, want all 0");
    else passed++;
    total++;
    if (num_inst !== '0) $display("FAIL reset_num_inst: got %0d want 0", num_inst);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if (bus.read_m !== 1'b1) $display("FAIL reset_first_fetch: read_m got %b want 1", bus.read_m);
    else passed++;
  endtask

  task automatic test_alu();
    do_reset();
    exp_q.push_back(exp_latency(4'd15, 6'd0, 0, 0));
    run_inst(4'd15, 6'd0, 0, 0, 1'b0);
    total++;
    if (obs.cycles !== exp_q.pop_front()) $display("FAIL add_latency: got %0d want 4", obs.cycles);
    else passed++;
    total++;
    if (obs.rd_if !== 1) $display("FAIL add_fetch_read: got %0d cycles want 1", obs.rd_if);
    else passed++;
    total++;
    if (obs.regw_cycle !== 4 || obs.regw !== 1)
      $display("FAIL add_reg_write: got cycle %0d count %0d want cycle 4 count 1", obs.regw_cycle, obs.regw);
    else passed++;
    total++;
    if (obs.regdst !== 2'd1) $display("FAIL add_reg_dst: got %0d want 1", obs.regdst);
    else passed++;
    total++;
    if (num_inst !== 4'd1) $display("FAIL add_num_inst: got %0d want 1", num_inst);
    else passed++;
  endtask

  task automatic test_lwd_waits();
    exp_q.push_back(exp_latency(4'd7, 6'd0, 3, 2));
    run_inst(4'd7, 6'd0, 3, 2, 1'b0);
    total++;
    if (obs.cycles !== exp_q.pop_front()) $display("FAIL lwd_latency: got %0d want 10", obs.cycles);
    else passed++;
    total++;
    if (obs.rd_if !== 4 || obs.rd_mem !== 3)
      $display("FAIL lwd_read_hold: got if %0d mem %0d want if 4 mem 3", obs.rd_if, obs.rd_mem);
    else passed++;
    total++;
    if (obs.wbsel !== 2'd1) $display("FAIL lwd_wb_sel: got %0d want 1", obs.wbsel);
    else passed++;
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      exp_q.push_back(exp_latency(4'd1, 6'd0, 0, 0));
      run_inst(4'd1, 6'd0, 0, 0, t[0]);
      total++;
      if (obs.cycles !== exp_q.pop_front())
        $display("FAIL beq_latency_taken%0d: got %0d want 3", t, obs.cycles);
      else passed++;
      total++;
      if (obs.pcw_late !== t || (t == 1 && obs.pcsrc !== 2'd1))
        $display("FAIL beq_pc_write_taken%0d: got %0d pulses src %0d want %0d src 1", t, obs.pcw_late, obs.pcsrc, t);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    exp_q.push_back(exp_latency(4'd15, 6'd40, 0, 0));
    run_inst(4'd15, 6'd40, 0, 0, 1'b0);
    total++;
    if (obs.cycles !== exp_q.pop_front()) $display("FAIL illegal_latency: got %0d want 2", obs.cycles);
    else passed++;
    total++;
    if (obs.ill !== 1 || obs.regw !== 0 || obs.wr !== 0)
      $display("FAIL illegal_strobes: got ill %0d regw %0d wr %0d want 1 0 0", obs.ill, obs.regw, obs.wr);
    else passed++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    total++;
    if (bus.read_m !== 1'b1) $display("FAIL illegal_next_fetch: read_m got %b want 1", bus.read_m);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[10] = '{4'd5, 4'd8, 4'd10, 4'd15, 4'd15, 4'd0, 4'd6, 4'd4, 4'd15, 4'd9};
    logic [5:0] fns[10] = '{6'd0, 6'd0, 6'd0, 6'd26, 6'd25, 6'd0, 6'd0, 6'd0, 6'd1, 6'd0};
    logic [1:0] src_want;
    int fw, mw;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 2));
      exp_q.push_back(exp_latency(ops[i], fns[i], fw, mw));
      run_inst(ops[i], fns[i], fw, mw, 1'b1);
      total++;
      if (obs.cycles !== exp_q.pop_front())
        $display("FAIL b2b_latency_%0d: got %0d want %0d", i, obs.cycles, exp_latency(ops[i], fns[i], fw, mw));
      else passed++;
      total++;
      if (obs.regw !== exp_regw(ops[i], fns[i]) || obs.both !== 0 || obs.irw !== 1)
        $display("FAIL b2b_strobes_%0d: got regw %0d both %0d irw %0d want %0d 0 1", i, obs.regw, obs.both, obs.irw, exp_regw(ops[i], fns[i]));
      else passed++;
      if (ops[i] == 4'd10 || fns[i] == 6'd26 || fns[i] == 6'd25 || ops[i] == 4'd9) begin
        src_want = (ops[i] == 4'd10 || ops[i] == 4'd9) ? 2'd2 : 2'd3;
        total++;
        if (obs.pcw_late !== 1 || obs.pcsrc !== src_want)
          $display("FAIL b2b_jump_%0d: got %0d pulses src %0d want 1 src %0d", i, obs.pcw_late, obs.pcsrc, src_want);
        else passed++;
      end
      if (ops[i] == 4'd10 || fns[i] == 6'd26) begin
        total++;
        if (obs.regdst !== 2'd2 || obs.wbsel !== 2'd2)
          $display("FAIL b2b_link_%0d: got dst %0d wb %0d want 2 2", i, obs.regdst, obs.wbsel);
        else passed++;
      end
    end
  endtask

  task automatic test_wwd_hlt();
    int bad;
    do_reset();
    run_inst(4'd15, 6'd28, 0, 0, 1'b0);
    total++;
    if (obs.opf !== 1 || obs.cycles !== 2)
      $display("FAIL wwd_flag: got %0d pulses %0d cycles want 1 pulse 2 cycles", obs.opf, obs.cycles);
    else passed++;
    run_inst(4'd15, 6'd29, 0, 0, 1'b0);
    total++;
    if (obs.cycles !== 2) $display("FAIL hlt_latency: got %0d want 2", obs.cycles);
    else passed++;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      if ((bus.read_m | bus.write_m | ir_write | pc_write | reg_write |
           output_port_flag | illegal) !== 1'b0 || is_halted !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL halt_quiet: got %0d bad cycles want 0", bad);
    else passed++;
    total++;
    if (num_inst !== 4'd2) $display("FAIL halt_num_inst: got %0d want 2", num_inst);
    else passed++;
  endtask

  task automatic test_reset_mem();
    bit seen;
    seen = 0;
    do_reset();
    run_inst(4'd9, 6'd0, 0, 0, 1'b0);
    @(negedge clk);
    bus.mem_ready = 1'b1; opcode = 4'd0;
    #2;
    total++;
    if (ir_write !== 1'b1) $display("FAIL swd_fetch: ir_write got %b want 1", ir_write);
    else passed++;
    @(posedge clk);
    #1 opcode = 4'd8; func = 6'd0; bus.mem_ready = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #2;
      if (bus.write_m) seen = 1;
    end
    total++;
    if (!seen) $display("FAIL swd_reach_mem: write_m got 0 want 1 within 10 cycles");
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (bus.write_m !== 1'b0 || num_inst !== '0)
      $display("FAIL swd_reset_abort: got write_m %b num_inst %0d want 0 0", bus.write_m, num_inst);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.read_m !== 1'b1 || num_inst !== '0)
      $display("FAIL swd_refetch: got read_m %b num_inst %0d want 1 0", bus.read_m, num_inst);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) run_inst(4'd9, 6'd0, 0, 0, 1'b0);
    total++;
    if (num_inst !== 4'd15) $display("FAIL wrap_max: got %0d want 15", num_inst);
    else passed++;
    run_inst(4'd9, 6'd0, 0, 0, 1'b0);
    total++;
    if (num_inst !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", num_inst);
    else passed++;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_lwd_waits();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_wwd_hlt();
    test_reset_mem();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
